inst_prefetch_buffer: RTL

In-order instruction prefetch queue between the instruction memory and the F/D pipeline register of the RV32I core. It issues sequential word fetches over a valid/ready request channel and accepts in-order responses. It buffers up to DEPTH `{pc, inst}` pairs and presents them to decode through a valid/ready handshake. On a branch, jal or jalr redirect it flushes its contents and discards any responses still in flight.

---
 rtl/inst_prefetch_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/inst_prefetch_buffer.sv
// In-order instruction prefetch queue between imem and F/D.
// Issues sequential fetches, buffers {pc, inst}, flushes on redirect.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]   inflight;
  logic          req_fire;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic [63:0]   head;
  logic [31:0]   aligned_pc;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign aligned_pc = {redirect_pc[31:2], 2'b00};

  // Buffered entries plus in-flight fetches may never exceed DEPTH,
  // so every response always has a free slot waiting for it.
  assign inflight = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_valid = reset & ~redirect & (inflight < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is ignored.
  assign rsp_ok = imem_rsp_valid & (outstanding != '0);
  assign push   = rsp_ok & (drop_cnt == '0) & ~redirect;

  assign out_valid = (count != '0) & ~redirect;
  assign pop       = out_valid & out_ready;

  assign head     = mem[rd_ptr];
  assign out_pc   = out_valid ? head[63:32] : 32'h0;
  assign out_inst = out_valid ? head[31:0]  : NOP;

  // Fetch and response PC tracking; redirect restarts both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= aligned_pc;
      resp_pc  <= aligned_pc;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push)     resp_pc  <= resp_pc + 32'd4;
    end
  end

  // Occupancy, pointers and in-flight bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(rsp_ok);
      drop_cnt    <= outstanding - CW'(rsp_ok);
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Entry storage; contents only matter while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {resp_pc, imem_rsp_data};
  end

endmodule
